// File: rtl/dc_8to32.sv
// rtl/dc_8to32.sv - byte-to-word packer with frame sideband, short-word padding and one-word hold buffer
module dc_8to32 #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         WCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_vld_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_sof,
    input  logic              s_eof,
    output logic              s_rdy_o,
    output logic              m_vld_o,
    output logic [31:0]       m_data_o,
    output logic              m_sof,
    output logic [2:0]        m_eof_sb,
    input  logic              m_rdy_i,
    output logic [WCNT_W-1:0] frame_words_o,
    output logic              sof_err_o
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t             state, state_nxt;
    logic [31:0]        acc;
    logic [1:0]         byte_cnt;
    logic               acc_sof;
    logic [31:0]        hold_data;
    logic               hold_sof;
    logic [2:0]         hold_eof_sb;
    logic [WCNT_W-1:0]  wcnt;

    logic               take;
    logic               complete;
    logic               out_free;
    logic               word_acc;
    logic [1:0]         lane;
    logic [31:0]        word_nxt;
    logic               word_sof;
    logic [2:0]         eof_sb_nxt;

    assign s_rdy_o  = (state != HOLD);
    assign word_acc = m_vld_o && m_rdy_i;
    assign out_free = !m_vld_o || m_rdy_i;
    // In IDLE only a start-of-frame byte is kept; anything else is consumed and dropped.
    assign take       = s_vld_i && s_rdy_o && (state == FILL || s_sof);
    assign lane       = s_sof ? 2'd0 : byte_cnt;
    assign complete   = take && (lane == 2'd3 || s_eof);
    assign word_sof   = s_sof || acc_sof;
    assign eof_sb_nxt = s_eof ? {1'b1, lane} : 3'b000;

    // A fresh word starts from all-pad lanes so a short final word is already padded.
    always_comb begin
        word_nxt = s_sof ? {4{PAD_BYTE}} : acc;
        word_nxt[{lane, 3'b000} +: 8] = s_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FILL: begin
                if (take) begin
                    if (!complete)     state_nxt = FILL;
                    else if (out_free) state_nxt = s_eof ? IDLE : FILL;
                    else               state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (m_rdy_i) state_nxt = hold_eof_sb[2] ? IDLE : FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= {4{PAD_BYTE}};
            byte_cnt    <= 2'd0;
            acc_sof     <= 1'b0;
            hold_data   <= 32'd0;
            hold_sof    <= 1'b0;
            hold_eof_sb <= 3'b000;
            m_vld_o     <= 1'b0;
            m_data_o    <= 32'd0;
            m_sof       <= 1'b0;
            m_eof_sb    <= 3'b000;
            sof_err_o   <= 1'b0;
        end else begin
            if (take && state == FILL && s_sof && byte_cnt != 2'd0)
                sof_err_o <= 1'b1;

            if (take) begin
                if (complete) begin
                    acc      <= {4{PAD_BYTE}};
                    byte_cnt <= 2'd0;
                    acc_sof  <= 1'b0;
                    if (!out_free) begin
                        hold_data   <= word_nxt;
                        hold_sof    <= word_sof;
                        hold_eof_sb <= eof_sb_nxt;
                    end
                end else begin
                    acc      <= word_nxt;
                    byte_cnt <= lane + 2'd1;
                    acc_sof  <= word_sof;
                end
            end

            if (complete && out_free) begin
                m_vld_o  <= 1'b1;
                m_data_o <= word_nxt;
                m_sof    <= word_sof;
                m_eof_sb <= eof_sb_nxt;
            end else if (state == HOLD && m_rdy_i) begin
                m_vld_o  <= 1'b1;
                m_data_o <= hold_data;
                m_sof    <= hold_sof;
                m_eof_sb <= hold_eof_sb;
            end else if (word_acc) begin
                m_vld_o  <= 1'b0;
            end
        end
    end

    // wcnt holds the number of words of the current frame already handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt          <= '0;
            frame_words_o <= '0;
        end else if (word_acc) begin
            wcnt <= m_sof ? WCNT_W'(1) : wcnt + WCNT_W'(1);
            if (m_eof_sb[2])
                frame_words_o <= m_sof ? WCNT_W'(1) : wcnt + WCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dc_8to32.sv
// tb/tb_dc_8to32.sv - directed self-checking bench for dc_8to32
module tb_dc_8to32;

    logic        clk;
    logic        rst_n;
    logic        s_vld_i;
    logic [7:0]  s_data_i;
    logic        s_sof;
    logic        s_eof;
    logic        s_rdy_o;
    logic        m_vld_o;
    logic [31:0] m_data_o;
    logic        m_sof;
    logic [2:0]  m_eof_sb;
    logic        m_rdy_i;
    logic [15:0] frame_words_o;
    logic        sof_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    logic [35:0] got[$];

    dc_8to32 #(.PAD_BYTE(8'hAA), .WCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_vld_i(s_vld_i), .s_data_i(s_data_i), .s_sof(s_sof), .s_eof(s_eof), .s_rdy_o(s_rdy_o),
        .m_vld_o(m_vld_o), .m_data_o(m_data_o), .m_sof(m_sof), .m_eof_sb(m_eof_sb), .m_rdy_i(m_rdy_i),
        .frame_words_o(frame_words_o), .sof_err_o(sof_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word is transferred at the next rising edge when valid and ready are both high mid-cycle.
    always @(negedge clk)
        if (rst_n && m_vld_o && m_rdy_i) got.push_back({m_sof, m_eof_sb, m_data_o});

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic [35:0] exp);
        logic [35:0] obs;
        obs = (idx < got.size()) ? got[idx] : 36'hx;
        check(tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof);
        logic ok;
        ok = 1'b0;
        s_vld_i = 1'b1; s_data_i = d; s_sof = sof; s_eof = eof;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = s_rdy_o;
            @(posedge clk);
            #1;
        end
        s_vld_i = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        if (ok) n_acc++;
        check("byte_accepted", {35'd0, ok}, 36'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s_vld_i = 1'b0; s_data_i = 8'h00; s_sof = 1'b0; s_eof = 1'b0; m_rdy_i = 1'b1;
        idle_cycles(2);
        check("rst_m_vld",       {35'd0, m_vld_o},   36'd0);
        check("rst_m_data",      {4'd0, m_data_o},   36'd0);
        check("rst_m_sof_eof",   {32'd0, m_sof, m_eof_sb}, 36'd0);
        check("rst_frame_words", {20'd0, frame_words_o}, 36'd0);
        check("rst_sof_err",     {35'd0, sof_err_o}, 36'd0);
        check("rst_s_rdy",       {35'd0, s_rdy_o},   36'd1);
        rst_n = 1'b1;
        idle_cycles(1);

        // 8-byte frame, full final word
        got.delete();
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), i == 1, i == 8);
            if (i == 4) begin
                check("lat_m_vld",  {35'd0, m_vld_o}, 36'd1);
                check("lat_m_data", {4'd0, m_data_o}, {4'd0, 32'h04030201});
            end
        end
        idle_cycles(3);
        check("f8_count", 36'(got.size()), 36'd2);
        check_word("f8_w0", 0, {1'b1, 3'b000, 32'h04030201});
        check_word("f8_w1", 1, {1'b0, 3'b111, 32'h08070605});
        check("f8_frame_words", {20'd0, frame_words_o}, 36'd2);

        // 6-byte frame, padded final word
        got.delete();
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), i == 0, i == 5);
        idle_cycles(3);
        check("f6_count", 36'(got.size()), 36'd2);
        check_word("f6_w0", 0, {1'b1, 3'b000, 32'h14131211});
        check_word("f6_w1", 1, {1'b0, 3'b101, 32'hAAAA1615});
        check("f6_frame_words", {20'd0, frame_words_o}, 36'd2);

        // 12-byte stream with 10 cycles of downstream stall
        got.delete();
        n_acc = 0;
        m_rdy_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) send_byte(8'h21 + 8'(i), i == 0, i == 11);
            end
            begin
                idle_cycles(10);
                check("bp_accepted", 36'(n_acc), 36'd8);
                check("bp_s_rdy",    {35'd0, s_rdy_o}, 36'd0);
                check("bp_m_hold",   {m_sof, m_eof_sb, m_data_o}, {1'b1, 3'b000, 32'h24232221});
                m_rdy_i = 1'b1;
            end
        join
        idle_cycles(4);
        check("bp_total_bytes", 36'(n_acc), 36'd12);
        check("bp_count", 36'(got.size()), 36'd3);
        check_word("bp_w0", 0, {1'b1, 3'b000, 32'h24232221});
        check_word("bp_w1", 1, {1'b0, 3'b000, 32'h28272625});
        check_word("bp_w2", 2, {1'b0, 3'b111, 32'h2C2B2A29});
        check("bp_frame_words", {20'd0, frame_words_o}, 36'd3);

        // junk bytes before sof are dropped
        got.delete();
        for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), i == 0, i == 3);
        idle_cycles(3);
        check("pre_count", 36'(got.size()), 36'd1);
        check_word("pre_w0", 0, {1'b1, 3'b111, 32'h34333231});
        check("pre_frame_words", {20'd0, frame_words_o}, 36'd1);

        // sof mid-word discards the partial word
        got.delete();
        check("serr_before", {35'd0, sof_err_o}, 36'd0);
        send_byte(8'h41, 1'b1, 1'b0);
        send_byte(8'h42, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h51 + 8'(i), i == 0, i == 3);
        idle_cycles(3);
        check("serr_flag", {35'd0, sof_err_o}, 36'd1);
        check("serr_count", 36'(got.size()), 36'd1);
        check_word("serr_w0", 0, {1'b1, 3'b111, 32'h54535251});

        // one-byte frame
        got.delete();
        send_byte(8'h61, 1'b1, 1'b1);
        idle_cycles(3);
        check("one_count", 36'(got.size()), 36'd1);
        check_word("one_w0", 0, {1'b1, 3'b100, 32'hAAAAAA61});
        check("one_frame_words", {20'd0, frame_words_o}, 36'd1);
        check("serr_sticky", {35'd0, sof_err_o}, 36'd1);

        // async reset while a word is waiting and another is partial
        m_rdy_i = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h71 + 8'(i), i == 0, 1'b0);
        check("prerst_m_vld", {35'd0, m_vld_o}, 36'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_out",       {m_sof, m_eof_sb, m_data_o}, 36'd0);
        check("arst_m_vld",       {35'd0, m_vld_o}, 36'd0);
        check("arst_frame_words", {20'd0, frame_words_o}, 36'd0);
        check("arst_sof_err",     {35'd0, sof_err_o}, 36'd0);
        check("arst_s_rdy",       {35'd0, s_rdy_o}, 36'd1);
        idle_cycles(2);
        rst_n = 1'b1;
        m_rdy_i = 1'b1;
        idle_cycles(1);
        got.delete();
        for (int i = 0; i < 4; i++) send_byte(8'h81 + 8'(i), i == 0, i == 3);
        idle_cycles(3);
        check("post_count", 36'(got.size()), 36'd1);
        check_word("post_w0", 0, {1'b1, 3'b111, 32'h84838281});
        check("post_frame_words", {20'd0, frame_words_o}, 36'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
